// File: rtl/sensor_ctrl_pkg.sv
// Shared defaults and the capture-mode encoding for the sensor capture controller.
package sensor_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 64;
  localparam int unsigned NCH_DEF    = 4;

  typedef enum logic {
    SCTRL_ONESHOT = 1'b0,
    SCTRL_RING    = 1'b1
  } sctrl_mode_e;

endpackage

// File: rtl/sensor_chan.sv
// One capture channel: private sample buffer, write pointer, fill count, sticky
// overrun flag, capture request, level interrupt and an async physical read port.
module sensor_chan
  import sensor_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              ring,
  input  logic              ready,
  input  logic [AW:0]       thresh,
  input  logic [DATA_W-1:0] sample,
  input  logic [AW-1:0]     raddr,
  output logic              sen,
  output logic [DATA_W-1:0] rdata,
  output logic [AW:0]       count,
  output logic              irq
);

  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovr_q, ovr_d;
  logic              full, accept;
  logic [AW-1:0]     ridx;
  sctrl_mode_e       mode;

  assign mode   = sctrl_mode_e'(ring);
  assign full   = (count_q == CntFull);
  // Request is held low during reset so nothing is accepted at the release edge.
  assign sen    = ~rst & en & ~clear & ((mode == SCTRL_RING) | ~full);
  assign accept = sen & ready;

  // Next-state: clear beats accept; a full-buffer accept only happens in ring mode.
  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    if (clear) begin
      wptr_d  = '0;
      count_d = '0;
      ovr_d   = 1'b0;
    end else if (accept) begin
      wptr_d = wptr_q + AW'(1);
      if (full) begin
        ovr_d = 1'b1;
      end else begin
        count_d = count_q + (AW+1)'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  // Sample storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= sample;
    end
  end

  // Logical index 0 is the oldest sample; low count bits are count mod DEPTH.
  assign ridx  = wptr_q - count_q[AW-1:0] + raddr;
  assign rdata = mem_q[ridx];
  assign count = count_q;
  assign irq   = full | ovr_q | ((thresh != '0) && (count_q >= thresh));

endmodule

// File: rtl/sensor_ctrl_mc.sv
// Multi-channel sensor capture controller: NCH independent channels, a channel
// read mux with a registered data output and a combinational count readback.
module sensor_ctrl_mc
  import sensor_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  parameter  int unsigned NCH    = NCH_DEF,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        sctrl_en,
  input  logic [NCH-1:0]        sctrl_clear,
  input  logic [NCH-1:0]        sctrl_ring,
  input  logic [AW:0]           sctrl_thresh,
  input  logic [CW-1:0]         sctrl_ch,
  input  logic [AW-1:0]         sctrl_addr,
  output logic [DATA_W-1:0]     sctrl_out,
  output logic [AW:0]           sctrl_count,
  output logic [NCH-1:0]        sctrl_interrupt,
  input  logic [NCH-1:0]        sensor_ready,
  input  logic [NCH*DATA_W-1:0] sensor_out,
  output logic [NCH-1:0]        sensor_en
);

  logic [DATA_W-1:0] ch_rdata [NCH];
  logic [AW:0]       ch_count [NCH];
  logic [DATA_W-1:0] rd_sel;
  logic [AW:0]       cnt_sel;
  logic              ch_ok;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sensor_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (sctrl_en[c]),
      .clear  (sctrl_clear[c]),
      .ring   (sctrl_ring[c]),
      .ready  (sensor_ready[c]),
      .thresh (sctrl_thresh),
      .sample (sensor_out[c*DATA_W +: DATA_W]),
      .raddr  (sctrl_addr),
      .sen    (sensor_en[c]),
      .rdata  (ch_rdata[c]),
      .count  (ch_count[c]),
      .irq    (sctrl_interrupt[c])
    );
  end

  assign ch_ok = (32'(sctrl_ch) < NCH);

  // Channel select; out-of-range channels read as zero.
  always_comb begin
    rd_sel  = '0;
    cnt_sel = '0;
    if (ch_ok) begin
      rd_sel  = ch_rdata[sctrl_ch];
      cnt_sel = ch_count[sctrl_ch];
    end
  end

  assign sctrl_count = cnt_sel;

  // Registered read data (one-cycle read latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sctrl_out <= '0;
    end else begin
      sctrl_out <= rd_sel;
    end
  end

endmodule

// File: tb/tb_sensor_ctrl_mc.sv
// Self-checking bench for sensor_ctrl_mc: directed scenarios plus a randomized
// phase, all checked against a per-channel queue model of the buffers.
module tb_sensor_ctrl_mc;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = 2;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    en, clear, ring, ready;
  logic [AW:0]       thresh;
  logic [CW-1:0]     sctrl_ch;
  logic [AW-1:0]     sctrl_addr;
  logic [DW-1:0]     sctrl_out;
  logic [AW:0]       sctrl_count;
  logic [NCH-1:0]    sctrl_interrupt;
  logic [NCH*DW-1:0] sdata;
  logic [NCH-1:0]    sensor_en;

  // Small second instance (3 channels, depth 4) so a channel select >= NCH is reachable.
  logic [2:0]  b_en, b_clear, b_ring, b_ready, b_irq, b_sen, b_thresh, b_count;
  logic [1:0]  b_ch, b_addr;
  logic [31:0] b_out;
  logic [95:0] b_sdata;

  int tests;
  int fails;

  // Reference model: retained samples per channel, oldest first, plus overrun flag.
  logic [DW-1:0] mq [NCH][$];
  bit            movr [NCH];

  sensor_ctrl_mc #(.DATA_W(DW), .DEPTH(DEPTH), .NCH(NCH)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .sctrl_en        (en),
    .sctrl_clear     (clear),
    .sctrl_ring      (ring),
    .sctrl_thresh    (thresh),
    .sctrl_ch        (sctrl_ch),
    .sctrl_addr      (sctrl_addr),
    .sctrl_out       (sctrl_out),
    .sctrl_count     (sctrl_count),
    .sctrl_interrupt (sctrl_interrupt),
    .sensor_ready    (ready),
    .sensor_out      (sdata),
    .sensor_en       (sensor_en)
  );

  sensor_ctrl_mc #(.DATA_W(32), .DEPTH(4), .NCH(3)) u_dut3 (
    .clk             (clk),
    .rst             (rst),
    .sctrl_en        (b_en),
    .sctrl_clear     (b_clear),
    .sctrl_ring      (b_ring),
    .sctrl_thresh    (b_thresh),
    .sctrl_ch        (b_ch),
    .sctrl_addr      (b_addr),
    .sctrl_out       (b_out),
    .sctrl_count     (b_count),
    .sctrl_interrupt (b_irq),
    .sensor_ready    (b_ready),
    .sensor_out      (b_sdata),
    .sensor_en       (b_sen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check capture requests and the read issued this cycle, then advance the model.
  task automatic cycle();
    logic [NCH-1:0] sen_exp;
    logic           rd_chk;
    logic [DW-1:0]  rd_exp;
    #1;
    for (int c = 0; c < NCH; c++) begin
      sen_exp[c] = en[c] & ~clear[c] & (ring[c] | (mq[c].size() < int'(DEPTH)));
    end
    chk("sensor_en", 64'(sensor_en), 64'(sen_exp));
    rd_chk = 1'b0;
    rd_exp = '0;
    if (int'(sctrl_addr) < mq[sctrl_ch].size()) begin
      rd_chk = 1'b1;
      rd_exp = mq[sctrl_ch][sctrl_addr];
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (clear[c]) begin
        mq[c].delete();
        movr[c] = 1'b0;
      end else if (sen_exp[c] && ready[c]) begin
        mq[c].push_back(sdata[c*DW +: DW]);
        if (mq[c].size() > int'(DEPTH)) begin
          void'(mq[c].pop_front());
          movr[c] = 1'b1;
        end
      end
    end
    if (rd_chk) chk("sctrl_out", 64'(sctrl_out), 64'(rd_exp));
  endtask

  task automatic check_state();
    logic [NCH-1:0] irq_exp;
    #1;
    for (int c = 0; c < NCH; c++) begin
      irq_exp[c] = (mq[c].size() == int'(DEPTH)) | movr[c] |
                   ((thresh != 0) && (mq[c].size() >= int'(thresh)));
    end
    chk("sctrl_count", 64'(sctrl_count), 64'(mq[sctrl_ch].size()));
    chk("sctrl_interrupt", 64'(sctrl_interrupt), 64'(irq_exp));
  endtask

  task automatic rd(input int ch, input int addr, input logic [DW-1:0] e, input string tag);
    sctrl_ch   = CW'(ch);
    sctrl_addr = AW'(addr);
    cycle();
    chk(tag, 64'(sctrl_out), 64'(e));
  endtask

  task automatic cnt_is(input int ch, input int e, input string tag);
    sctrl_ch = CW'(ch);
    #1;
    chk(tag, 64'(sctrl_count), 64'(e));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    en = '0; clear = '0; ring = '0; ready = '0; sdata = '0; thresh = '0;
    sctrl_ch = '0; sctrl_addr = '0;
    b_en = '0; b_clear = '0; b_ring = '0; b_ready = '0; b_thresh = '0;
    b_ch = '0; b_addr = '0; b_sdata = '0;
    for (int c = 0; c < NCH; c++) movr[c] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'(sctrl_out), 64'd0);
    chk("rst_sen", 64'(sensor_en), 64'd0);
    chk("rst_irq", 64'(sctrl_interrupt), 64'd0);
    chk("rst_count", 64'(sctrl_count), 64'd0);
    rst = 1'b0;

    // One-shot fill of channel 0
    en[0] = 1'b1; ready[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sdata[31:0] = 32'h100 + 32'(i);
      cycle();
    end
    sdata[31:0] = 32'hdead;
    cycle();
    check_state();
    chk("oneshot_sen_low", 64'(sensor_en[0]), 64'd0);
    chk("oneshot_irq", 64'(sctrl_interrupt[0]), 64'd1);
    rd(0, 0, 32'h100, "oneshot_addr0");
    rd(0, 63, 32'h13f, "oneshot_addr63");
    en[0] = 1'b0;

    // Ring capture on channel 1
    ring[1] = 1'b1; en[1] = 1'b1; ready[1] = 1'b1;
    for (int i = 0; i < 70; i++) begin
      sdata[63:32] = 32'(i);
      cycle();
    end
    en[1] = 1'b0;
    check_state();
    cnt_is(1, 64, "ring_count");
    chk("ring_irq", 64'(sctrl_interrupt[1]), 64'd1);
    rd(1, 0, 32'd6, "ring_addr0");
    rd(1, 63, 32'd69, "ring_addr63");

    // Watermark on channel 2
    thresh = 7'd10; en[2] = 1'b1; ready[2] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sdata[95:64] = 32'h200 + 32'(i);
      cycle();
    end
    chk("wm_below", 64'(sctrl_interrupt[2]), 64'd0);
    sdata[95:64] = 32'h209;
    cycle();
    chk("wm_reached", 64'(sctrl_interrupt[2]), 64'd1);
    en[2] = 1'b0; clear[2] = 1'b1;
    cycle();
    clear[2] = 1'b0;
    check_state();
    chk("wm_clear_irq", 64'(sctrl_interrupt[2]), 64'd0);
    cnt_is(2, 0, "wm_clear_count");
    thresh = '0;

    // Clear beats a same-cycle accept on channel 3
    en[3] = 1'b1; ready[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sdata[127:96] = 32'h300 + 32'(i);
      cycle();
    end
    cnt_is(3, 5, "ch3_count5");
    clear[3] = 1'b1;
    #1;
    chk("clear_sen_low", 64'(sensor_en[3]), 64'd0);
    cycle();
    clear[3] = 1'b0; en = '0;
    cnt_is(3, 0, "clear_count0");

    // All channels capture every cycle
    clear = '1;
    cycle();
    clear = '0; ring = '0; en = '1; ready = '1;
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < NCH; c++) sdata[c*DW +: DW] = (32'(c + 1) << 24) | 32'(i);
      cycle();
    end
    en = '0;
    for (int c = 0; c < NCH; c++) begin
      cnt_is(c, 20, "all_count");
      rd(c, 0, 32'(c + 1) << 24, "all_addr0");
      rd(c, 19, (32'(c + 1) << 24) | 32'd19, "all_addr19");
    end
    check_state();

    // Out-of-range channel select on the 3-channel instance
    b_en = 3'b111; b_ready = 3'b111;
    b_sdata = {32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};
    repeat (6) @(posedge clk);
    #1;
    b_en = '0;
    b_ch = 2'd3; b_addr = 2'd0;
    @(posedge clk);
    #1;
    chk("oor_out", 64'(b_out), 64'd0);
    chk("oor_count", 64'(b_count), 64'd0);
    b_ch = 2'd2;
    @(posedge clk);
    #1;
    chk("b_ch2_count", 64'(b_count), 64'd4);
    chk("b_ch2_out", 64'(b_out), 64'hcccc0002);

    // Randomized traffic against the model
    clear = '1;
    cycle();
    clear = '0;
    for (int n = 0; n < 1500; n++) begin
      en    = NCH'($urandom);
      ready = NCH'($urandom);
      if ($urandom_range(0, 15) == 0) ring = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        clear[c] = ($urandom_range(0, 299) == 0);
        sdata[c*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 63) == 0) thresh = (AW+1)'($urandom_range(0, DEPTH));
      sctrl_ch   = CW'($urandom);
      sctrl_addr = AW'($urandom);
      cycle();
      check_state();
    end

    // Reset in the middle of a capture
    clear = '1;
    cycle();
    clear = '0; thresh = '0; ring = '0; en = '0; ready = '0;
    en[0] = 1'b1; ready[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sdata[31:0] = 32'h400 + 32'(i);
      cycle();
    end
    cnt_is(0, 30, "pre_rst_count");
    rst = 1'b1;
    #1;
    chk("midrst_out", 64'(sctrl_out), 64'd0);
    chk("midrst_sen", 64'(sensor_en), 64'd0);
    chk("midrst_irq", 64'(sctrl_interrupt), 64'd0);
    chk("midrst_count", 64'(sctrl_count), 64'd0);
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      movr[c] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sdata[31:0] = 32'ha0 + 32'(i);
      cycle();
    end
    en = '0;
    cnt_is(0, 3, "post_rst_count");
    rd(0, 0, 32'ha0, "post_rst_addr0");
    rd(0, 2, 32'ha2, "post_rst_addr2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
